// File: rtl/cluster_link_pkg.sv
// Shared constants, types and helpers for the cluster hit-map link (transmit and receive sides).
package cluster_link_pkg;

  localparam int unsigned ROW_W       = 38;
  localparam int unsigned WORD_W      = 16;
  localparam int unsigned POP_W       = 7;
  localparam int unsigned ID_W        = 8;
  localparam int unsigned FRAME_WORDS = 8;
  localparam int unsigned WIDX_W      = 3;

  localparam logic [WORD_W-1:0] HEADER    = 16'hAAAA;
  localparam logic [WORD_W-1:0] IDLE_WORD = 16'h0000;

  localparam logic [WIDX_W-1:0] W_HDR = 3'd0;
  localparam logic [WIDX_W-1:0] W_TRL = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

  // One buffered row pair plus its hit count, captured at push time.
  typedef struct packed {
    logic [ROW_W-1:0] row1;
    logic [ROW_W-1:0] row0;
    logic [POP_W-1:0] pop;
  } row_pair_t;

  function automatic logic [POP_W-1:0] popcount(input logic [ROW_W-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < ROW_W; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/cluster_frame_tx_if.sv
// Row-pair input handshake and 16-bit link output of the cluster frame transmitter.
interface cluster_frame_tx_if;
  import cluster_link_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [ROW_W-1:0]  in_row0;
  logic [ROW_W-1:0]  in_row1;
  logic              link_en;
  logic [WORD_W-1:0] tx_data;
  logic              tx_sof;
  logic              tx_eof;

  modport master (
    output in_valid, in_row0, in_row1, link_en,
    input  in_ready, tx_data, tx_sof, tx_eof
  );

  modport slave (
    input  in_valid, in_row0, in_row1, link_en,
    output in_ready, tx_data, tx_sof, tx_eof
  );

endinterface

// File: rtl/cluster_row_fifo.sv
// Small synchronous FIFO of row pairs; exposes next-cycle full/empty for registered handshakes.
module cluster_row_fifo
  import cluster_link_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  row_pair_t wr_data,
  input  logic      pop,
  output row_pair_t rd_data,
  output logic      full_next_c,
  output logic      empty_next_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  row_pair_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            full;
  logic            empty;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Occupancy tracking; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  assign full_next_c  = (count_next == CW'(DEPTH));
  assign empty_next_c = (count_next == CW'(0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= full_next_c;
      empty <= empty_next_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/cluster_frame_tx.sv
// Cluster hit-map link transmitter: buffers row pairs and serializes each as an 8-word frame.
module cluster_frame_tx
  import cluster_link_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  cluster_frame_tx_if.slave lnk,
  output logic              busy,
  output logic [ID_W-1:0]   frame_id
);

  tx_state_e         state_q;
  tx_state_e         state_d;
  logic [WIDX_W-1:0] w_q;
  logic [WIDX_W-1:0] w_d;

  logic [WORD_W-1:0] tx_data_q;
  logic [WORD_W-1:0] tx_data_d;
  logic              tx_sof_q;
  logic              tx_sof_d;
  logic              tx_eof_q;
  logic              tx_eof_d;
  logic              in_ready_q;
  logic              busy_d;

  logic              push_c;
  logic              pop_c;
  logic              full_next_c;
  logic              empty_next_c;
  row_pair_t         wr_pair;
  row_pair_t         head;
  logic [ID_W-1:0]   frame_id_inc;

  function automatic logic [WORD_W-1:0] row_word(input logic [ROW_W-1:0] row,
                                                 input logic [1:0]       sel);
    case (sel)
      2'd0:    return row[15:0];
      2'd1:    return row[31:16];
      default: return WORD_W'(row[ROW_W-1:32]);
    endcase
  endfunction

  assign push_c       = lnk.in_valid && in_ready_q;
  assign pop_c        = (state_q == ST_SEND) && lnk.link_en && (w_q == W_TRL);
  assign frame_id_inc = frame_id + ID_W'(1);

  assign wr_pair = '{row1: lnk.in_row1,
                     row0: lnk.in_row0,
                     pop:  popcount(lnk.in_row0) + popcount(lnk.in_row1)};

  cluster_row_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (push_c),
    .wr_data      (wr_pair),
    .pop          (pop_c),
    .rd_data      (head),
    .full_next_c  (full_next_c),
    .empty_next_c (empty_next_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      w_q     <= W_HDR;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
    end
  end

  // A push on the launch edge counts, so the header follows an accept by one cycle.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    case (state_q)
      ST_IDLE: begin
        if (lnk.link_en && !empty_next_c) begin
          state_d = ST_SEND;
          w_d     = W_HDR;
        end
      end
      ST_SEND: begin
        if (lnk.link_en) begin
          if (w_q == W_TRL) begin
            w_d     = W_HDR;
            state_d = empty_next_c ? ST_IDLE : ST_SEND;
          end else begin
            w_d = w_q + WIDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        w_d     = W_HDR;
      end
    endcase
  end

  // Word mux; a stalled link sees IDLE_WORD with no framing flags.
  always_comb begin
    tx_data_d = IDLE_WORD;
    tx_sof_d  = 1'b0;
    tx_eof_d  = 1'b0;
    busy_d    = (state_d == ST_SEND) || !empty_next_c;
    if (state_q == ST_SEND && lnk.link_en) begin
      case (w_q)
        W_HDR: begin
          tx_data_d = HEADER;
          tx_sof_d  = 1'b1;
        end
        W_TRL: begin
          tx_data_d = {frame_id_inc, 1'b0, head.pop};
          tx_eof_d  = 1'b1;
        end
        3'd1, 3'd2, 3'd3: tx_data_d = row_word(head.row0, 2'(w_q - 3'd1));
        default:          tx_data_d = row_word(head.row1, 2'(w_q - 3'd4));
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data_q  <= IDLE_WORD;
      tx_sof_q   <= 1'b0;
      tx_eof_q   <= 1'b0;
      in_ready_q <= 1'b0;
      busy       <= 1'b0;
      frame_id   <= '0;
    end else begin
      tx_data_q  <= tx_data_d;
      tx_sof_q   <= tx_sof_d;
      tx_eof_q   <= tx_eof_d;
      in_ready_q <= !full_next_c;
      busy       <= busy_d;
      if (pop_c) frame_id <= frame_id_inc;
    end
  end

  assign lnk.tx_data  = tx_data_q;
  assign lnk.tx_sof   = tx_sof_q;
  assign lnk.tx_eof   = tx_eof_q;
  assign lnk.in_ready = in_ready_q;

endmodule

// File: tb/tb_cluster_frame_tx.sv
// Self-checking bench for cluster_frame_tx: directed frame scenarios plus a randomized run against a frame-level model.
module tb_cluster_frame_tx;

  localparam logic [15:0] HDR  = 16'hAAAA;
  localparam logic [15:0] IDLE = 16'h0000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       busy;
  logic [7:0] frame_id;

  cluster_frame_tx_if lnk();

  cluster_frame_tx #(.FIFO_DEPTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .lnk      (lnk),
    .busy     (busy),
    .frame_id (frame_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame word w of a pair {row1,row0}; id is the frame count before this frame.
  function automatic logic [15:0] frame_word(input logic [75:0] pr, input int w, input logic [7:0] id);
    logic [37:0] r0, r1, r;
    r0 = pr[37:0];
    r1 = pr[75:38];
    r  = (w >= 4) ? r1 : r0;
    case (w)
      0:       return HDR;
      1, 4:    return r[15:0];
      2, 5:    return r[31:16];
      3, 6:    return {10'b0, r[37:32]};
      default: return {8'(id + 8'd1), 1'b0, 7'($countones(r0) + $countones(r1))};
    endcase
  endfunction

  // Reference model: queue of accepted pairs, current frame progress, frame counter.
  logic [75:0] pq[$];
  bit          m_active = 1'b0;
  int          m_w      = 0;
  logic [7:0]  m_id     = 8'd0;
  bit          m_ready  = 1'b0;
  bit          m_acc    = 1'b0;
  logic [15:0] e_data   = 16'h0;
  bit          e_sof    = 1'b0;
  bit          e_eof    = 1'b0;
  bit          mon_en   = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pq.delete();
      m_active = 1'b0; m_w = 0; m_id = 8'd0; m_ready = 1'b0;
      e_data = IDLE; e_sof = 1'b0; e_eof = 1'b0;
    end else begin
      m_acc  = lnk.in_valid && m_ready;
      e_data = IDLE; e_sof = 1'b0; e_eof = 1'b0;
      if (m_active && lnk.link_en) begin
        e_data = frame_word(pq[0], m_w, m_id);
        e_sof  = (m_w == 0);
        e_eof  = (m_w == 7);
        if (m_w == 7) begin
          m_id     = m_id + 8'd1;
          void'(pq.pop_front());
          m_active = 1'b0;
        end else begin
          m_w++;
        end
      end
      if (m_acc) pq.push_back({lnk.in_row1, lnk.in_row0});
      if (!m_active && lnk.link_en && pq.size() > 0) begin
        m_active = 1'b1;
        m_w      = 0;
      end
      m_ready = (pq.size() < 2);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("mdl_data", 32'(lnk.tx_data), 32'(e_data));
      check("mdl_sof", 32'(lnk.tx_sof), 32'(e_sof));
      check("mdl_eof", 32'(lnk.tx_eof), 32'(e_eof));
      check("mdl_ready", 32'(lnk.in_ready), 32'(m_ready));
      check("mdl_busy", 32'(busy), 32'(m_active || pq.size() != 0));
      check("mdl_frame_id", 32'(frame_id), 32'(m_id));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    lnk.in_valid = 1'b0;
    lnk.link_en  = 1'b1;
    @(negedge clk);
    check("rst_data", 32'(lnk.tx_data), 32'(IDLE));
    check("rst_sof", 32'(lnk.tx_sof), 0);
    check("rst_eof", 32'(lnk.tx_eof), 0);
    check("rst_ready", 32'(lnk.in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_id", 32'(frame_id), 0);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_ready_up", 32'(lnk.in_ready), 1);
  endtask

  task automatic push_pair(input logic [37:0] r0, input logic [37:0] r1);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    lnk.in_row0  = r0;
    lnk.in_row1  = r1;
    lnk.in_valid = 1'b1;
    do begin
      acc = lnk.in_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < 40);
    lnk.in_valid = 1'b0;
    if (!acc) check("push_timeout", 32'(lnk.in_ready), 1);
  endtask

  task automatic wait_sof(input string tag);
    int n;
    n = 0;
    while (!lnk.tx_sof && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!lnk.tx_sof) check(tag, 32'(lnk.tx_sof), 1);
  endtask

  function automatic logic [37:0] mk_row(input int i, input int salt);
    return {6'(i + salt), 16'(16'h1234 + i + salt), 16'(16'h5678 + i)};
  endfunction

  logic [15:0] sf_exp [8];
  logic [15:0] wd [8];
  logic [75:0] pr;
  int          k, pushed, nz, eofs, cyc;
  bit          acc;

  initial begin
    lnk.in_valid = 1'b0;
    lnk.in_row0  = '0;
    lnk.in_row1  = '0;
    lnk.link_en  = 1'b1;
    sf_exp = '{16'hAAAA, 16'h0001, 16'h0000, 16'h003F, 16'h0000, 16'h8000, 16'h0000, 16'h0108};
    mon_en = 1'b1;

    // Single frame with known words and latency
    do_reset();
    push_pair(38'h3F_0000_0001, 38'h00_8000_0000);
    check("sf_pre_hdr", 32'(lnk.tx_data), 32'(IDLE));
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      check("sf_word", 32'(lnk.tx_data), 32'(sf_exp[i]));
      check("sf_sof", 32'(lnk.tx_sof), 32'(i == 0));
      check("sf_eof", 32'(lnk.tx_eof), 32'(i == 7));
      if (i < 7) @(negedge clk);
    end
    check("sf_frame_id", 32'(frame_id), 1);
    @(negedge clk);
    check("sf_after_idle", 32'(lnk.tx_data), 32'(IDLE));

    // Back-to-back frames with in_valid held high
    do_reset();
    pushed = 0; k = -1; acc = 1'b0;
    lnk.in_row0 = mk_row(0, 1); lnk.in_row1 = mk_row(0, 9); lnk.in_valid = 1'b1;
    for (int c = 0; c < 80 && k < 24; c++) begin
      acc = lnk.in_valid && lnk.in_ready;
      @(negedge clk);
      if (acc) begin
        pushed++;
        if (pushed == 2) check("b2b_ready_low", 32'(lnk.in_ready), 0);
        if (pushed < 3) begin
          lnk.in_row0 = mk_row(pushed, 1);
          lnk.in_row1 = mk_row(pushed, 9);
        end else begin
          lnk.in_valid = 1'b0;
        end
      end
      if (k < 0 && lnk.tx_sof) k = 0;
      if (k >= 0) begin
        check("b2b_gap", 32'(lnk.tx_data != IDLE), 1);
        check("b2b_sof", 32'(lnk.tx_sof), 32'(k % 8 == 0));
        check("b2b_eof", 32'(lnk.tx_eof), 32'(k % 8 == 7));
        if (k % 8 == 7) check("b2b_id", 32'(frame_id), 32'(k / 8 + 1));
        if (k == 7) check("b2b_ready_up", 32'(lnk.in_ready), 1);
        k++;
      end
    end
    lnk.in_valid = 1'b0;
    if (k < 24) check("b2b_timeout", 32'(k), 24);

    // Three-cycle stall before word 4
    do_reset();
    pr = {38'h15_2468_ACE0, 38'h2A_1357_9BDF};
    push_pair(pr[37:0], pr[75:38]);
    wait_sof("st_sof_timeout");
    nz = 0;
    for (int s = 0; s < 11; s++) begin
      if (s >= 4 && s <= 6) begin
        check("st_idle", 32'(lnk.tx_data), 32'(IDLE));
        check("st_idle_flags", 32'({lnk.tx_sof, lnk.tx_eof}), 0);
      end else begin
        check("st_word", 32'(lnk.tx_data), 32'(frame_word(pr, (s < 4) ? s : s - 3, 8'd0)));
        check("st_eof", 32'(lnk.tx_eof), 32'(s == 10));
      end
      if (lnk.tx_data != IDLE) nz++;
      if (s == 3) lnk.link_en = 1'b0;
      if (s == 6) lnk.link_en = 1'b1;
      if (s < 10) @(negedge clk);
    end
    check("st_nonidle", 32'(nz), 8);

    // All-ones rows
    do_reset();
    push_pair({38{1'b1}}, {38{1'b1}});
    wait_sof("ones_sof_timeout");
    for (int i = 0; i < 8; i++) begin
      wd[i] = lnk.tx_data;
      if (i < 7) @(negedge clk);
    end
    check("ones_w3", 32'(wd[3]), 32'h003F);
    check("ones_w6", 32'(wd[6]), 32'h003F);
    check("ones_pop", 32'(wd[7][7:0]), 32'h4C);
    check("ones_id", 32'(wd[7][15:8]), 32'h01);

    // Reset while word 3 is next
    do_reset();
    push_pair(mk_row(3, 2), mk_row(4, 5));
    wait_sof("mid_sof_timeout");
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_data", 32'(lnk.tx_data), 32'(IDLE));
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_sof", 32'(lnk.tx_sof), 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    pr = {mk_row(7, 3), mk_row(6, 1)};
    push_pair(pr[37:0], pr[75:38]);
    wait_sof("mid_sof2_timeout");
    for (int i = 0; i < 8; i++) begin
      check("mid_word", 32'(lnk.tx_data), 32'(frame_word(pr, i, 8'd0)));
      if (i < 7) @(negedge clk);
    end
    check("mid_frame_id", 32'(frame_id), 1);

    // Randomized traffic through a full frame_id wrap
    do_reset();
    eofs = 0;
    cyc  = 0;
    while (eofs < 256 && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      if (lnk.tx_eof) begin
        eofs++;
        if (eofs == 256) begin
          check("wrap_trl_id", 32'(lnk.tx_data[15:8]), 0);
          check("wrap_frame_id", 32'(frame_id), 0);
        end
      end
      lnk.in_valid = ($urandom_range(3) != 0);
      lnk.in_row0  = 38'({$urandom(), $urandom()});
      lnk.in_row1  = 38'({$urandom(), $urandom()});
      lnk.link_en  = ($urandom_range(7) != 0);
    end
    if (eofs < 256) check("wrap_timeout", 32'(eofs), 256);
    lnk.in_valid = 1'b0;
    lnk.link_en  = 1'b1;
    repeat (40) @(negedge clk);
    check("drain_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
